// File: rtl/exp22_alu.sv
// Eight-operation unsigned ALU with a registered result, carry and zero flag.
// A new operation is accepted every cycle; results appear one clock later.
module exp22_alu #(
  parameter int unsigned WIDTH = 8
) (
  output logic [WIDTH-1:0] out,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  // Widened add/sub: the top bit is carry-out for ADD and borrow for SUB.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
  end

  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    case (opcode)
      OP_ADD: begin
        out_d   = sum_ext[WIDTH-1:0];
        carry_d = sum_ext[WIDTH];
      end
      OP_SUB: begin
        out_d   = diff_ext[WIDTH-1:0];
        carry_d = diff_ext[WIDTH];
      end
      OP_AND: out_d = a & b;
      OP_OR:  out_d = a | b;
      OP_NOT: out_d = ~a;
      OP_XOR: out_d = a ^ b;
      OP_SHL: begin
        out_d   = {a[WIDTH-2:0], 1'b0};
        carry_d = a[WIDTH-1];
      end
      OP_SHR: begin
        out_d   = {1'b0, a[WIDTH-1:1]};
        carry_d = a[0];
      end
    endcase
    zero_d = (out_d == '0);
  end

  // Zero is held low during reset even though out is also zero then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_exp22_alu.sv
// Directed-vector bench for exp22_alu: table of hand-computed results plus
// reset, input-hold and random-sweep sequences.
module tb_exp22_alu;

  logic [7:0] out, a, b;
  logic [2:0] opcode;
  logic       clk, rst_n, carry, zero;

  exp22_alu #(.WIDTH(8)) dut (
    .out(out), .opcode(opcode), .a(a), .b(b),
    .clk(clk), .rst_n(rst_n), .carry(carry), .zero(zero)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] e_out;
    logic       e_carry;
    logic       e_zero;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] e_out,
                       input logic e_carry, input logic e_zero);
    n_vec++;
    if (out !== e_out || carry !== e_carry || zero !== e_zero) begin
      n_err++;
      $display("FAIL %s: got out=%h carry=%b zero=%b, expected out=%h carry=%b zero=%b",
               name, out, carry, zero, e_out, e_carry, e_zero);
    end
  endtask

  // Independent reference using integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] m_out, output logic m_carry);
    int s;
    m_carry = 1'b0;
    case (op)
      3'd0: begin s = int'(ma) + int'(mb); m_out = 8'(s % 256); m_carry = (s >= 256); end
      3'd1: begin s = int'(ma) - int'(mb) + 256; m_out = 8'(s % 256); m_carry = (ma < mb); end
      3'd2: m_out = ma & mb;
      3'd3: m_out = ma | mb;
      3'd4: m_out = 8'hFF - ma;
      3'd5: m_out = ma ^ mb;
      3'd6: begin m_out = 8'((int'(ma) * 2) % 256); m_carry = (ma >= 8'd128); end
      default: begin m_out = 8'(int'(ma) / 2); m_carry = (ma % 2 == 1); end
    endcase
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    opcode = op;
    a      = va;
    b      = vb;
  endtask

  initial begin
    logic [7:0] m_out;
    logic       m_carry;

    vecs.push_back('{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{3'd2, 8'hCA, 8'h0F, 8'h0A, 1'b0, 1'b0});
    vecs.push_back('{3'd3, 8'hCA, 8'h0F, 8'hCF, 1'b0, 1'b0});
    vecs.push_back('{3'd4, 8'hCA, 8'h0F, 8'h35, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 8'hCA, 8'h0F, 8'hC5, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0});
    vecs.push_back('{3'd7, 8'h81, 8'hFF, 8'h40, 1'b1, 1'b0});
    vecs.push_back('{3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{3'd1, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{3'd1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{3'd4, 8'hFF, 8'h12, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{3'd5, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{3'd6, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{3'd7, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{3'd6, 8'h7F, 8'hAA, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 8'hFE, 8'h55, 8'h7F, 1'b0, 1'b0});

    // Reset asserted before any clock edge must clear outputs at once.
    rst_n  = 1'b1;
    opcode = 3'd0;
    a      = 8'hF0;
    b      = 8'h20;
    #10 rst_n = 1'b0;
    #1 check("reset_immediate", 8'h00, 1'b0, 1'b0);

    // Outputs hold reset values across edges while rst_n stays low.
    repeat (2) @(posedge clk);
    #1 check("reset_hold", 8'h00, 1'b0, 1'b0);

    // Release between edges; first edge loads the first table vector.
    @(negedge clk);
    opcode = vecs[0].op;
    a      = vecs[0].va;
    b      = vecs[0].vb;
    rst_n  = 1'b1;
    @(posedge clk);
    #1 check("vec0", vecs[0].e_out, vecs[0].e_carry, vecs[0].e_zero);

    for (int i = 1; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].va, vecs[i].vb);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_carry, vecs[i].e_zero);
    end

    // Input changes between edges must not reach the outputs.
    drive(3'd3, 8'h0F, 8'hF0);
    @(posedge clk);
    #1 check("hold_pre", 8'hFF, 1'b0, 1'b0);
    #10 opcode = 3'd0; a = 8'h00; b = 8'h00;
    #20 check("hold_post", 8'hFF, 1'b0, 1'b0);

    // Random sweep across opcodes 0..4, one step per clock.
    for (int i = 0; i < 5; i++) begin
      drive(3'(i), 8'($urandom_range(255)), 8'($urandom_range(255)));
      model(opcode, a, b, m_out, m_carry);
      @(posedge clk);
      #1 check($sformatf("sweep%0d", i), m_out, m_carry, (m_out == 8'h00));
    end

    // Mid-stream async reset discards the pending result.
    drive(3'd0, 8'hF0, 8'h20);
    @(posedge clk);
    #1 check("pre_reset", 8'h10, 1'b1, 1'b0);
    #20 rst_n = 1'b0;
    opcode = 3'd0; a = 8'h01; b = 8'h01;
    #1 check("async_reset", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("reset_discard", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_release", 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exp22_alu.md
EXP22_ALU -- requirements
Module: exp22

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; all requirements below are stated for WIDTH=8.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: out  output  8  registered ALU result (first positional port).
REQ-006 Port: opcode  input  3  operation select (second positional port).
REQ-007 Port: a  input  8  operand A, unsigned (third positional port).
REQ-008 Port: b  input  8  operand B, unsigned (fourth positional port).
REQ-009 Port: carry  output  1  registered carry/borrow/shifted-out bit.
REQ-010 Port: zero  output  1  registered flag, high when the registered out equals 0.
REQ-011 The positional order of the first four ports SHALL be out, opcode, a, b; clk, rst_n, carry and zero SHALL connect by name.

Function
REQ-012 Opcode 0 (ADD) SHALL give out = (a+b) mod 256 and carry = bit 8 of the 9-bit sum.
REQ-013 Opcode 1 (SUB) SHALL give out = (a-b) mod 256 and carry = 1 exactly when a < b (borrow).
REQ-014 Opcode 2 (AND) SHALL give out = a & b and carry = 0.
REQ-015 Opcode 3 (OR) SHALL give out = a | b and carry = 0.
REQ-016 Opcode 4 (NOT) SHALL give out = ~a, ignore b, and give carry = 0.
REQ-017 Opcode 5 (XOR) SHALL give out = a ^ b and carry = 0.
REQ-018 Opcode 6 (SHL) SHALL give out = {a[6:0],1'b0} and carry = a[7], ignoring b.
REQ-019 Opcode 7 (SHR, logical) SHALL give out = {1'b0,a[7:1]} and carry = a[0], ignoring b.
REQ-020 The result SHALL be computed combinationally from the current a, b and opcode.
REQ-021 The result SHALL be registered on every rising clk edge, giving a latency of exactly 1 cycle.
REQ-022 There is no handshake; a new operation is accepted every cycle.
REQ-023 zero SHALL be registered in the same edge as out and SHALL equal (next out == 0).
REQ-024 All arithmetic SHALL be unsigned with wrap-around modulo 256; no overflow flag exists.
REQ-025 Operand or opcode changes between clock edges SHALL NOT affect the outputs until the next rising edge.
REQ-026 Every 3-bit opcode value SHALL be defined, so no default or X output is permitted.

Reset
REQ-027 When rst_n is low, out=8'h00, carry=0 and zero=0 SHALL apply immediately, without waiting for clk.
REQ-028 The outputs SHALL hold their reset values while rst_n is low, regardless of clk or inputs.
REQ-029 Asserting reset mid-stream SHALL discard the pending result.
REQ-030 On the first rising edge after rst_n rises, the outputs SHALL load the result of the inputs present at that edge.

Verification
REQ-031 ADD with wrap: a=8'hF0, b=8'h20, op=0 -> after 1 edge, out=8'h10, carry=1, zero=0.
REQ-032 SUB with borrow: a=8'h05, b=8'h07, op=1 -> out=8'hFE, carry=1; with a=8'h07, b=8'h07 -> out=8'h00, carry=0, zero=1.
REQ-033 Logic ops with a=8'hCA, b=8'h0F:
- op=2 -> out=8'h0A.
- op=3 -> out=8'hCF.
- op=4 -> out=8'h35.
- op=5 -> out=8'hC5.
- For each of these, carry=0.
REQ-034 Shifts with a=8'h81:
- op=6 -> out=8'h02, carry=1.
- op=7 -> out=8'h40, carry=1.
REQ-035 Random sweep: start at opcode 0, with random a and b every 100 ns, and increment opcode each step through 5 steps; each registered out SHALL match the reference model one cycle later.
REQ-036 Async reset: drive rst_n low between clock edges while out=8'h10 -> out=8'h00, carry=0, zero=0 before the next edge; release rst_n with a=1, b=1, op=0 -> out=8'h02 at the next edge.
